// File: rtl/cnn_pool_pkg.sv
// Shared definitions for the CNN pooling path: pooling modes and width helpers.
package cnn_pool_pkg;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_AVG = 1'b1
  } pool_mode_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // AVG needs headroom for the sum of POOL*POOL samples; MAX keeps the native width.
  function automatic int acc_width(input int data_w, input int pool, input int mode);
    return (mode == int'(MODE_AVG)) ? data_w + 2 * clog2(pool) : data_w;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One pooling lane: horizontal accumulator, per-window-column line buffer and OP/FIN datapath.
module pool_lane
  import cnn_pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NWIN   = 14,
  parameter int WC_W   = 4,
  parameter int POOL   = 2,
  parameter int MODE   = 0,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              px0,
  input  logic              px_end,
  input  logic              py0,
  input  logic              py_end,
  input  logic [WC_W-1:0]   wc,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] result,
  output logic              load
);

  localparam int ACC_W = acc_width(DATA_W, POOL, MODE);
  localparam int SHIFT = (MODE == int'(MODE_AVG)) ? 2 * clog2(POOL) : 0;

  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        x_ext;
  logic [ACC_W-1:0]        h;
  logic [ACC_W-1:0]        v;
  logic [ACC_W-1:0]        line_rd;
  logic signed [ACC_W-1:0] v_signed;
  logic [ACC_W-1:0]        line_buf [NWIN];

  function automatic logic [ACC_W-1:0] op(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic ge;
    if (MODE == int'(MODE_AVG)) return a + b;
    ge = (SIGNED != 0) ? ($signed(a) >= $signed(b)) : (a >= b);
    return ge ? a : b;
  endfunction

  always_comb begin
    x_ext = {ACC_W{(SIGNED != 0) && x[DATA_W-1]}};
    x_ext[DATA_W-1:0] = x;
  end

  assign line_rd  = line_buf[wc];
  assign h        = px0 ? x_ext : op(acc, x_ext);
  assign v        = py0 ? h : op(line_rd, h);
  assign v_signed = v;

  // Arithmetic shift floors toward -inf for signed averages.
  assign result = (SIGNED != 0) ? DATA_W'(v_signed >>> SHIFT) : DATA_W'(v >> SHIFT);
  assign load   = accept && px_end && py_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (accept) begin
      acc <= h;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && px_end && !py_end) begin
      line_buf[wc] <= v;
    end
  end

endmodule

// File: rtl/maxpool_stream.sv
// Streaming POOLxPOOL / stride-POOL max or average pooling over a raster-order valid/ready stream.
module maxpool_stream
  import cnn_pool_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 1,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int POOL     = 2,
  parameter int MODE     = 0,
  parameter int SIGNED   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*DATA_W-1:0]   s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CHANNELS*DATA_W-1:0]   m_data,
  output logic                         m_last
);

  localparam int NWIN = IMG_W / POOL;
  localparam int NROW = IMG_H / POOL;
  localparam int PX_W = (clog2(POOL) > 0) ? clog2(POOL) : 1;
  localparam int WC_W = (clog2(NWIN) > 0) ? clog2(NWIN) : 1;
  localparam int RW_W = (clog2(NROW) > 0) ? clog2(NROW) : 1;

  if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0 || POOL < 2 || (POOL & (POOL - 1)) != 0) begin : g_bad_params
    $error("maxpool_stream: IMG_W/IMG_H must be multiples of POOL and POOL a power of two >= 2");
  end

  logic [PX_W-1:0]            px;
  logic [PX_W-1:0]            py;
  logic [WC_W-1:0]            wc;
  logic [RW_W-1:0]            prow;
  logic                       accept;
  logic                       px0;
  logic                       px_end;
  logic                       py0;
  logic                       py_end;
  logic                       wc_end;
  logic                       prow_end;
  logic                       load;
  logic [CHANNELS-1:0]        loads;
  logic [CHANNELS*DATA_W-1:0] results;

  assign s_ready  = !m_valid || m_ready;
  assign accept   = s_valid && s_ready;
  assign px0      = (px == '0);
  assign px_end   = (px == PX_W'(POOL - 1));
  assign py0      = (py == '0);
  assign py_end   = (py == PX_W'(POOL - 1));
  assign wc_end   = (wc == WC_W'(NWIN - 1));
  assign prow_end = (prow == RW_W'(NROW - 1));

  // col = wc*POOL+px and row = prow*POOL+py, so wraps cascade px -> wc -> py -> prow.
  always_ff @(posedge clk) begin
    if (rst) begin
      px   <= '0;
      py   <= '0;
      wc   <= '0;
      prow <= '0;
    end else if (accept) begin
      if (!px_end) begin
        px <= px + 1'b1;
      end else begin
        px <= '0;
        if (!wc_end) begin
          wc <= wc + 1'b1;
        end else begin
          wc <= '0;
          if (!py_end) begin
            py <= py + 1'b1;
          end else begin
            py   <= '0;
            prow <= prow_end ? '0 : prow + 1'b1;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    pool_lane #(
      .DATA_W (DATA_W),
      .NWIN   (NWIN),
      .WC_W   (WC_W),
      .POOL   (POOL),
      .MODE   (MODE),
      .SIGNED (SIGNED)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .accept (accept),
      .px0    (px0),
      .px_end (px_end),
      .py0    (py0),
      .py_end (py_end),
      .wc     (wc),
      .x      (s_data[i*DATA_W +: DATA_W]),
      .result (results[i*DATA_W +: DATA_W]),
      .load   (loads[i])
    );
  end

  assign load = |loads;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= results;
      m_last  <= wc_end && prow_end;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench for maxpool_stream: four configurations checked against a window-level model.
module tb_maxpool_stream;

  localparam int ND = 4;
  localparam int CH  [ND] = '{2, 1, 1, 1};
  localparam int W   [ND] = '{4, 4, 4, 8};
  localparam int HH  [ND] = '{4, 4, 4, 8};
  localparam int P   [ND] = '{2, 2, 2, 4};
  localparam int AVG [ND] = '{0, 0, 1, 1};
  localparam int SG  [ND] = '{1, 0, 1, 1};

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        sv   [ND];
  logic [15:0] sd   [ND];
  logic        mr   [ND];
  logic        srdy [ND];
  logic        mv   [ND];
  logic        ml   [ND];
  logic [15:0] md   [ND];
  logic [15:0] md0;
  logic [7:0]  md1;
  logic [7:0]  md2;
  logic [7:0]  md3;

  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;
  bit          abort = 0;
  exp_t        expq [ND][$];
  logic [15:0] frame [$];

  assign md[0] = md0;
  assign md[1] = {8'h00, md1};
  assign md[2] = {8'h00, md2};
  assign md[3] = {8'h00, md3};

  maxpool_stream #(.DATA_W(8), .CHANNELS(2), .IMG_W(4), .IMG_H(4), .POOL(2), .MODE(0), .SIGNED(1)) u_dut0 (
    .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(srdy[0]), .s_data(sd[0]),
    .m_valid(mv[0]), .m_ready(mr[0]), .m_data(md0), .m_last(ml[0]));
  maxpool_stream #(.DATA_W(8), .CHANNELS(1), .IMG_W(4), .IMG_H(4), .POOL(2), .MODE(0), .SIGNED(0)) u_dut1 (
    .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(srdy[1]), .s_data(sd[1][7:0]),
    .m_valid(mv[1]), .m_ready(mr[1]), .m_data(md1), .m_last(ml[1]));
  maxpool_stream #(.DATA_W(8), .CHANNELS(1), .IMG_W(4), .IMG_H(4), .POOL(2), .MODE(1), .SIGNED(1)) u_dut2 (
    .clk(clk), .rst(rst), .s_valid(sv[2]), .s_ready(srdy[2]), .s_data(sd[2][7:0]),
    .m_valid(mv[2]), .m_ready(mr[2]), .m_data(md2), .m_last(ml[2]));
  maxpool_stream #(.DATA_W(8), .CHANNELS(1), .IMG_W(8), .IMG_H(8), .POOL(4), .MODE(1), .SIGNED(1)) u_dut3 (
    .clk(clk), .rst(rst), .s_valid(sv[3]), .s_ready(srdy[3]), .s_data(sd[3][7:0]),
    .m_valid(mv[3]), .m_ready(mr[3]), .m_data(md3), .m_last(ml[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog expired");
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    for (int d = 0; d < ND; d++) mr[d] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++)
        mr[d] = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  function automatic int lane_val(input int d, input logic [15:0] word, input int ln);
    logic [7:0] b;
    b = word[ln*8 +: 8];
    if (SG[d] != 0) return int'($signed(b));
    return int'(b);
  endfunction

  // Reference: each output is the max, or the floored mean, of its POOLxPOOL window.
  task automatic push_expected(input int d);
    int   nw;
    int   nh;
    int   n;
    int   v;
    int   best;
    int   sum;
    int   r;
    exp_t e;
    nw = W[d] / P[d];
    nh = HH[d] / P[d];
    n  = P[d] * P[d];
    for (int wy = 0; wy < nh; wy++) begin
      for (int wx = 0; wx < nw; wx++) begin
        e.data = '0;
        for (int ln = 0; ln < CH[d]; ln++) begin
          sum  = 0;
          best = 0;
          for (int y = 0; y < P[d]; y++) begin
            for (int x = 0; x < P[d]; x++) begin
              v = lane_val(d, frame[(wy * P[d] + y) * W[d] + wx * P[d] + x], ln);
              if ((x == 0 && y == 0) || v > best) best = v;
              sum += v;
            end
          end
          if (AVG[d] != 0) begin
            r = sum / n;
            if (sum < 0 && r * n != sum) r = r - 1;
          end else begin
            r = best;
          end
          e.data[ln*8 +: 8] = r[7:0];
        end
        e.last = (wy == nh - 1) && (wx == nw - 1);
        expq[d].push_back(e);
      end
    end
  endtask

  task automatic check(input string name, input int d, input logic [15:0] got, input logic [15:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s d%0d: got %h, need %h", name, d, got, need);
    end
  endtask

  task automatic send_px(input int d, input logic [15:0] px, input bit gaps);
    int budget;
    if (abort) return;
    if (gaps) begin
      while ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    sv[d] = 1'b1;
    sd[d] = px;
    budget = 0;
    forever begin
      @(negedge clk);
      if (srdy[d]) break;
      budget++;
      if (budget >= 300) begin
        checks++;
        errors++;
        abort = 1'b1;
        $display("FAIL accept_timeout d%0d: s_ready low for %0d cycles, need 1", d, budget);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    sv[d] = 1'b0;
  endtask

  task automatic send_frame(input int d, input bit gaps);
    push_expected(d);
    for (int i = 0; i < frame.size(); i++) send_px(d, frame[i], gaps);
  endtask

  task automatic random_frame(input int d);
    frame.delete();
    for (int i = 0; i < W[d] * HH[d]; i++) frame.push_back(16'($urandom));
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((expq[d].size() != 0 || mv[d]) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (expq[d].size() != 0 || mv[d]) begin
      checks++;
      errors++;
      $display("FAIL drain d%0d: %0d outputs pending, need 0", d, expq[d].size());
    end
  endtask

  // Monitor: scoreboard pops on each handshake, plus hold/stall checks under backpressure.
  initial begin
    logic        held      [ND];
    logic [15:0] held_data [ND];
    logic        held_last [ND];
    exp_t        e;
    for (int d = 0; d < ND; d++) held[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (rst) begin
          held[d] = 1'b0;
        end else begin
          if (held[d]) begin
            checks++;
            if (!mv[d] || md[d] != held_data[d] || ml[d] != held_last[d]) begin
              errors++;
              $display("FAIL hold d%0d: got valid=%0b data=%h last=%0b, need valid=1 data=%h last=%0b",
                       d, mv[d], md[d], ml[d], held_data[d], held_last[d]);
            end
          end
          if (mv[d] && !mr[d]) begin
            checks++;
            if (srdy[d]) begin
              errors++;
              $display("FAIL stall_ready d%0d: got s_ready=1, need 0", d);
            end
          end
          held[d]      = mv[d] && !mr[d];
          held_data[d] = md[d];
          held_last[d] = ml[d];
          if (mv[d] && mr[d]) begin
            checks++;
            if (expq[d].size() == 0) begin
              errors++;
              $display("FAIL out d%0d: got unexpected data=%h last=%0b, need no output", d, md[d], ml[d]);
            end else begin
              e = expq[d].pop_front();
              if (md[d] != e.data || ml[d] != e.last) begin
                errors++;
                $display("FAIL out d%0d: got data=%h last=%0b, need data=%h last=%0b",
                         d, md[d], ml[d], e.data, e.last);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      sv[d] = 1'b0;
      sd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("rst_m_valid", d, 16'(mv[d]), 16'd0);
      check("rst_m_data", d, md[d], 16'd0);
      check("rst_m_last", d, 16'(ml[d]), 16'd0);
      check("rst_s_ready", d, 16'(srdy[d]), 16'd1);
    end
    @(posedge clk);
    #1;

    // Two lanes, ascending/descending ramps, two frames back to back.
    frame.delete();
    for (int i = 0; i < 16; i++) frame.push_back({8'(16 - i), 8'(i + 1)});
    send_frame(0, 1'b0);
    send_frame(0, 1'b0);
    drain(0);

    // Signed vs unsigned max on the same bytes.
    random_frame(0);
    frame[0][7:0] = 8'h80;
    frame[1][7:0] = 8'hFF;
    frame[4][7:0] = 8'hFB;
    frame[5][7:0] = 8'hFD;
    send_frame(0, 1'b0);
    drain(0);
    send_frame(1, 1'b0);
    drain(1);

    // Averages with positive and negative floor, and a saturated-looking POOL=4 frame.
    random_frame(2);
    frame[0] = 16'd1;  frame[1] = 16'd2;  frame[4] = 16'd3;  frame[5] = 16'd5;
    frame[2] = 16'hFF; frame[3] = 16'hFE; frame[6] = 16'hFD; frame[7] = 16'hFC;
    send_frame(2, 1'b0);
    drain(2);
    frame.delete();
    for (int i = 0; i < 64; i++) frame.push_back(16'd127);
    send_frame(3, 1'b0);
    drain(3);

    // Downstream stalled long enough to hold a result for many cycles.
    random_frame(0);
    ready_mode = 2;
    fork
      send_frame(0, 1'b0);
      begin
        repeat (16) @(posedge clk);
        ready_mode = 0;
      end
    join
    drain(0);

    // Random valid/ready over three frames per configuration.
    ready_mode = 1;
    for (int d = 0; d < ND; d++) begin
      for (int f = 0; f < 3; f++) begin
        random_frame(d);
        send_frame(d, 1'b1);
      end
      drain(d);
    end
    ready_mode = 0;

    // Reset in the middle of row 1 with a result pending.
    ready_mode = 2;
    random_frame(0);
    for (int i = 0; i < 6; i++) send_px(0, frame[i], 1'b0);
    @(negedge clk);
    check("pending_before_rst", 0, 16'(mv[0]), 16'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_m_valid", 0, 16'(mv[0]), 16'd0);
    check("rst_mid_m_last", 0, 16'(ml[0]), 16'd0);
    ready_mode = 0;
    @(posedge clk);
    #1;
    random_frame(0);
    send_frame(0, 1'b0);
    drain(0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
